// File: rtl/fas_frame_sched.sv
// Frame scheduler for the FAS datapath.
// Packs the FIR sample stream into a ping-pong frame buffer. Each full bank
// gets one FFT pass and then one analysis pass. After NUM_FRAMES frames the
// block parks in S_DONE with all_done high.
//
// Handshakes: fir_valid has no ready. wr_en is the accept strobe. A sample
// offered while the target bank is still full is lost, and overrun records
// that loss. fft_start/fft_done and ana_start/ana_done are single-cycle
// request/completion pulses. A completion pulse is honoured only while the
// FSM waits for it.
module fas_frame_sched #(
  parameter int FRAME_LEN  = 16,
  parameter int ADDR_W     = 4,
  parameter int NUM_FRAMES = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fir_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_bank,
  output logic              fft_start,
  output logic              fft_bank,
  input  logic              fft_done,
  output logic              ana_start,
  input  logic              ana_done,
  output logic [3:0]        frame_cnt,
  output logic              all_done,
  output logic              overrun,
  output logic [2:0]        state_dbg
);

  localparam int CNT_W = ADDR_W + 4;
  localparam logic [CNT_W-1:0]  LIMIT      = CNT_W'(NUM_FRAMES * FRAME_LEN);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_LEN - 1);
  localparam logic [3:0]        FRAMES_MAX = 4'(NUM_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FFT_GO   = 3'd1,
    S_FFT_WAIT = 3'd2,
    S_ANA_GO   = 3'd3,
    S_ANA_WAIT = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       full;
  logic [CNT_W-1:0] accepted;
  logic             under_limit;
  logic             frame_end;
  logic             ana_fin;
  logic             drop;

  // Once the frame budget has been accepted, further samples are ignored.
  // They do not count as overrun.
  assign under_limit = (accepted < LIMIT);
  assign wr_en       = fir_valid & ~full[wr_bank] & under_limit;
  assign drop        = fir_valid &  full[wr_bank] & under_limit;
  assign frame_end   = wr_en & (wr_addr == LAST_ADDR);
  assign ana_fin     = (state == S_ANA_WAIT) & ana_done;

  // Write pointer, bank select, accepted-sample count and sticky overrun.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_addr  <= '0;
      wr_bank  <= 1'b0;
      accepted <= '0;
      overrun  <= 1'b0;
    end else begin
      if (wr_en) begin
        // FRAME_LEN is a power of two, so the address wraps on its own.
        wr_addr  <= wr_addr + ADDR_W'(1);
        accepted <= accepted + CNT_W'(1);
        if (frame_end) begin
          wr_bank <= ~wr_bank;
        end
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

  // Bank occupancy. The writer sets a bit and the scheduler clears one.
  // The writer cannot complete a bank that is still full, so the two
  // updates never target the same bit in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      full <= '0;
    end else begin
      if (ana_fin) begin
        full[fft_bank] <= 1'b0;
      end
      if (frame_end) begin
        full[wr_bank] <= 1'b1;
      end
    end
  end

  // Scheduler bookkeeping: the FFT bank flips and the frame count advances
  // when analysis completes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fft_bank  <= 1'b0;
      frame_cnt <= '0;
    end else if (ana_fin) begin
      fft_bank <= ~fft_bank;
      if (frame_cnt < FRAMES_MAX) begin
        frame_cnt <= frame_cnt + 4'd1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:     if (full[fft_bank]) state_nxt = S_FFT_GO;
      S_FFT_GO:   state_nxt = S_FFT_WAIT;
      S_FFT_WAIT: if (fft_done) state_nxt = S_ANA_GO;
      S_ANA_GO:   state_nxt = S_ANA_WAIT;
      S_ANA_WAIT: begin
        if (ana_done) begin
          state_nxt = ((frame_cnt + 4'd1) == FRAMES_MAX) ? S_DONE : S_IDLE;
        end
      end
      S_DONE:     state_nxt = S_DONE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs are decoded from the state flop, so they are glitch-free
  // and last exactly one state.
  always_comb begin
    fft_start = (state == S_FFT_GO);
    ana_start = (state == S_ANA_GO);
    all_done  = (state == S_DONE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_fas_frame_sched.sv
// Bench for fas_frame_sched: main instance (10 frames) plus a 1-frame build.
`timescale 1ns/1ps
module tb_fas_frame_sched;

  localparam int FRAME_LEN = 16;
  localparam int ADDR_W    = 4;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FFT_WAIT = 3'd2;
  localparam logic [2:0] ST_DONE     = 3'd5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (NUM_FRAMES = 10) ----------------
  logic              fir_valid = 1'b0;
  logic              fft_done  = 1'b0;
  logic              ana_done  = 1'b0;
  logic              wr_en, wr_bank, fft_start, fft_bank, ana_start, all_done, overrun;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        frame_cnt;
  logic [2:0]        state_dbg;

  fas_frame_sched #(.FRAME_LEN(16), .ADDR_W(4), .NUM_FRAMES(10)) dut (
    .clk(clk), .rst(rst), .fir_valid(fir_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_bank(wr_bank),
    .fft_start(fft_start), .fft_bank(fft_bank), .fft_done(fft_done),
    .ana_start(ana_start), .ana_done(ana_done),
    .frame_cnt(frame_cnt), .all_done(all_done), .overrun(overrun),
    .state_dbg(state_dbg)
  );

  // ---------------- DUT (NUM_FRAMES = 1) ----------------
  logic              fir_valid1 = 1'b0;
  logic              fft_done1  = 1'b0;
  logic              ana_done1  = 1'b0;
  logic              wr_en1, wr_bank1, fft_start1, fft_bank1, ana_start1, all_done1, overrun1;
  logic [ADDR_W-1:0] wr_addr1;
  logic [3:0]        frame_cnt1;
  logic [2:0]        state_dbg1;

  fas_frame_sched #(.FRAME_LEN(16), .ADDR_W(4), .NUM_FRAMES(1)) dut1 (
    .clk(clk), .rst(rst), .fir_valid(fir_valid1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_bank(wr_bank1),
    .fft_start(fft_start1), .fft_bank(fft_bank1), .fft_done(fft_done1),
    .ana_start(ana_start1), .ana_done(ana_done1),
    .frame_cnt(frame_cnt1), .all_done(all_done1), .overrun(overrun1),
    .state_dbg(state_dbg1)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [4:0] exp_q[$];        // expected {wr_bank, wr_addr} per accepted sample
  logic [0:0] exp_bank_q[$];   // expected fft_bank per fft_start
  logic [4:0] exp_wa;
  logic [0:0] exp_b;
  int exp_pos = 0;
  int n_wr = 0, n_fft = 0, n_ana = 0, n_wr1 = 0;
  int last_wr_cyc = 0;
  bit lat_chk = 1'b0;

  // FFT / analysis responder controls
  bit resp_en = 1'b0;
  int fft_dly = 20, ana_dly = 3;
  int fft_cnt = 0, ana_cnt = 0;
  bit spur_fft = 1'b0, spur_ana = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- monitor (samples on falling edge) ----------------
  always @(negedge clk) begin
    if (rst && wr_en) begin
      n_wr++;
      if (wr_addr == 4'(FRAME_LEN - 1)) last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'(wr_en), 32'd0);
      end else begin
        exp_wa = exp_q.pop_front();
        check("wr_bank_addr", 32'({wr_bank, wr_addr}), 32'(exp_wa));
      end
    end
    if (rst && fft_start) begin
      n_fft++;
      if (exp_bank_q.size() == 0) begin
        check("fft_unexpected", 32'(fft_start), 32'd0);
      end else begin
        exp_b = exp_bank_q.pop_front();
        check("fft_bank", 32'(fft_bank), 32'(exp_b));
      end
      if (lat_chk) check("fft_latency", 32'(cyc - last_wr_cyc), 32'd2);
    end
    if (rst && ana_start) n_ana++;
    if (rst && wr_en1) n_wr1++;
  end

  // ---------------- FFT / analysis responder ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        fft_cnt = 0;
        ana_cnt = 0;
      end else if (resp_en) begin
        if (fft_start) fft_cnt = fft_dly;
        if (ana_start) ana_cnt = ana_dly;
      end
      @(posedge clk); #1;
      fft_done = spur_fft;
      ana_done = spur_ana;
      spur_fft = 1'b0;
      spur_ana = 1'b0;
      if (fft_cnt > 0) begin
        fft_cnt--;
        if (fft_cnt == 0) fft_done = 1'b1;
      end
      if (ana_cnt > 0) begin
        ana_cnt--;
        if (ana_cnt == 0) ana_done = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks begin and end at posedge + 1.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    fir_valid = 1'b0;
    fir_valid1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_pos = 0;
    exp_q.delete();
    exp_bank_q.delete();
  endtask

  task automatic push_wr();
    exp_q.push_back({1'(exp_pos / FRAME_LEN), 4'(exp_pos % FRAME_LEN)});
    exp_pos++;
  endtask

  // Send n samples. Each sample is followed by 1..max_gap idle cycles
  // (max_gap = 0 means back-to-back).
  task automatic send(input int n, input int max_gap, input bit push);
    for (int i = 0; i < n; i++) begin
      fir_valid = 1'b1;
      if (push) push_wr();
      @(posedge clk); #1;
      if (max_gap > 0) begin
        fir_valid = 1'b0;
        repeat ($urandom_range(max_gap, 1)) @(posedge clk);
        #1;
      end
    end
    fir_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk);
    check({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
    check({tag, "_wr_bank"},   32'(wr_bank),   32'd0);
    check({tag, "_fft_bank"},  32'(fft_bank),  32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    check({tag, "_fft_start"}, 32'(fft_start), 32'd0);
    check({tag, "_ana_start"}, 32'(ana_start), 32'd0);
    check({tag, "_all_done"},  32'(all_done),  32'd0);
    check({tag, "_overrun"},   32'(overrun),   32'd0);
    check({tag, "_state"},     32'(state_dbg), 32'(ST_IDLE));
    @(posedge clk); #1;
  endtask

  task automatic spurious(input string tag, input logic [2:0] st, input int fc, input logic fb);
    spur_fft = 1'b1;
    spur_ana = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tag, "_state"},     32'(state_dbg), 32'(st));
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(fc));
    check({tag, "_fft_bank"},  32'(fft_bank),  32'(fb));
    @(posedge clk); #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    do_reset();
    check_reset("rst0");
    spurious("spur_idle", ST_IDLE, 0, 1'b0);

    // Paced stream of 160 samples. The first frame is back-to-back (latency
    // case). Later samples leave at least one idle cycle between them, so
    // each frame takes longer to fill than the 27 cycles one FFT + analysis
    // round takes, and no sample is dropped.
    resp_en = 1'b1;
    fft_dly = 20;
    ana_dly = 3;
    lat_chk = 1'b1;
    for (int k = 0; k < 10; k++) exp_bank_q.push_back(1'(k));
    send(16, 0, 1'b1);
    send(144, 3, 1'b1);
    for (int i = 0; i < 400 && !all_done; i++) @(negedge clk);
    check("strm_all_done",  32'(all_done),  32'd1);
    check("strm_frame_cnt", 32'(frame_cnt), 32'd10);
    check("strm_n_wr",      32'(n_wr),      32'd160);
    check("strm_n_fft",     32'(n_fft),     32'd10);
    check("strm_n_ana",     32'(n_ana),     32'd10);
    check("strm_overrun",   32'(overrun),   32'd0);
    check("strm_wr_left",   32'(exp_q.size()),      32'd0);
    check("strm_bank_left", 32'(exp_bank_q.size()), 32'd0);
    @(posedge clk); #1;

    // Past the limit: samples are ignored without overrun.
    send(20, 0, 1'b0);
    @(negedge clk);
    check("lim_n_wr",    32'(n_wr),    32'd160);
    check("lim_overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1;
    spurious("spur_done", ST_DONE, 10, 1'b0);
    lat_chk = 1'b0;

    // Overrun: the FFT stalls for 100 cycles while the stream continues.
    do_reset();
    fft_dly = 100;
    n_wr = 0;
    exp_bank_q.push_back(1'b0);
    exp_bank_q.push_back(1'b1);
    for (int i = 0; i < 32; i++) push_wr();
    fir_valid = 1'b1;
    repeat (32) @(posedge clk);
    @(negedge clk);
    check("ovr_33rd_wr_en", 32'(wr_en), 32'd0);
    check("ovr_n_wr_32",    32'(n_wr),  32'd32);
    @(negedge clk);
    check("ovr_set", 32'(overrun), 32'd1);
    for (int i = 0; i < 16; i++) push_wr();  // bank 0, addresses 0..15
    for (int i = 0; i < 200 && frame_cnt != 4'd1; i++) @(negedge clk);
    check("ovr_frame1", 32'(frame_cnt), 32'd1);
    repeat (20) @(posedge clk);
    #1 fir_valid = 1'b0;
    @(negedge clk);
    check("ovr_resume_left", 32'(exp_q.size()), 32'd0);
    check("ovr_sticky",      32'(overrun),      32'd1);
    check("ovr_bank_left",   32'(exp_bank_q.size()), 32'd0);
    @(posedge clk); #1;

    // Reset mid-FFT with a partial second frame (wr_addr = 7).
    do_reset();
    exp_bank_q.push_back(1'b0);
    send(23, 0, 1'b1);
    @(negedge clk);
    check("mid_state",   32'(state_dbg), 32'(ST_FFT_WAIT));
    check("mid_wr_addr", 32'(wr_addr),   32'd7);
    check("mid_wr_bank", 32'(wr_bank),   32'd1);
    check("mid_bank_left", 32'(exp_bank_q.size()), 32'd0);
    do_reset();
    check_reset("rst_mid");
    fft_dly = 20;
    exp_bank_q.push_back(1'b0);
    send(16, 0, 1'b1);
    for (int i = 0; i < 100 && frame_cnt != 4'd1; i++) @(negedge clk);
    check("mid_restart_frame", 32'(frame_cnt), 32'd1);
    check("mid_restart_bank",  32'(fft_bank),  32'd1);
    check("mid_restart_left",  32'(exp_q.size()), 32'd0);
    check("mid_restart_ovr",   32'(overrun),   32'd0);
    @(posedge clk); #1;

    // NUM_FRAMES = 1 build: one frame, then all further samples are ignored.
    resp_en = 1'b0;
    do_reset();
    n_wr1 = 0;
    fir_valid1 = 1'b1;
    for (int i = 0; i < 50 && !fft_start1; i++) @(negedge clk);
    check("nf1_fft_start", 32'(fft_start1), 32'd1);
    check("nf1_fft_bank",  32'(fft_bank1),  32'd0);
    @(posedge clk); #1 fft_done1 = 1'b1;
    @(posedge clk); #1 fft_done1 = 1'b0;
    for (int i = 0; i < 20 && !ana_start1; i++) @(negedge clk);
    check("nf1_ana_start", 32'(ana_start1), 32'd1);
    @(posedge clk); #1 ana_done1 = 1'b1;
    @(posedge clk); #1 ana_done1 = 1'b0;
    for (int i = 0; i < 20 && !all_done1; i++) @(negedge clk);
    check("nf1_all_done",  32'(all_done1),  32'd1);
    check("nf1_frame_cnt", 32'(frame_cnt1), 32'd1);
    check("nf1_n_wr",      32'(n_wr1),      32'd16);
    @(posedge clk);
    repeat (200) @(posedge clk);
    #1 fir_valid1 = 1'b0;
    @(negedge clk);
    check("nf1_post_n_wr",    32'(n_wr1),     32'd16);
    check("nf1_post_overrun", 32'(overrun1),  32'd0);
    check("nf1_post_done",    32'(all_done1), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
